fetch_decode_buffer: RTL and testbench
======================================

Name: fetch_decode_buffer

Overview:
IF/ID pipeline buffer on the consumer side of the Fetch stage. Accepts one 16-bit instruction word per cycle with its PC. Pairs immediate-bearing instructions with the following word as their immediate. Presents one complete instruction (instruction, immediate, pc) per valid beat to Decode. Honours hazard-unit stall and branch flush.

Parameters:
PC_W, 32, program counter width
WORD_W, 16, instruction/immediate word width
CNT_W, 16, width of issued-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  fetch word present this cycle
in_word  input  WORD_W  fetched memory word
in_pc  input  PC_W  address of in_word
in_ready  output  1  buffer accepts a word this cycle
stall  input  1  hazard unit freezes IF/ID
flush  input  1  squash buffer contents (taken branch/jump)
out_valid  output  1  complete instruction presented to Decode
out_instruction  output  WORD_W  instruction word (NOP 16'h0000 when invalid)
out_immediate  output  WORD_W  immediate word, 0 if none
out_has_imm  output  1  instruction carried an immediate
out_pc  output  PC_W  PC of the instruction word (not the immediate)
issued_count  output  CNT_W  number of out_valid beats issued since reset

Behaviour:
- One clock (clk); reset asynchronous, active-high. All state updates on rising clk.
- Reset: state=ST_FIRST, out_valid=0, out_instruction=0, out_immediate=0, out_has_imm=0, out_pc=0, issued_count=0, hold registers=0.
- in_ready = !stall && !flush (combinational). accept = in_valid && in_ready.
- is_imm(w): w[15:13]==IMM_GROUP (3'b110), from the shared package.
- Latency: a non-immediate word appears on outputs the cycle after acceptance. An immediate pair appears the cycle after its second word is accepted.
- State ST_FIRST:
  - accept && !is_imm: out_instruction=in_word, out_immediate=0, out_has_imm=0, out_pc=in_pc, out_valid=1. Stay.
  - accept && is_imm: hold_instr=in_word, hold_pc=in_pc, out_valid=0 (bubble), outputs zeroed. Go to ST_IMM.
  - no accept (not stall): out_valid=0, outputs zeroed. Stay.
- State ST_IMM:
  - accept: out_instruction=hold_instr, out_immediate=in_word, out_has_imm=1, out_pc=hold_pc, out_valid=1. Go to ST_FIRST. in_word is never checked with is_imm here.
  - no accept (not stall): out_valid=0. Stay in ST_IMM; hold registers retained.
- stall=1, flush=0: every output, the state and the hold registers are held unchanged. An incoming word is not accepted; Fetch must hold it.
- flush=1: priority over stall and in_valid. Next cycle: out_valid=0, outputs zeroed, state=ST_FIRST, hold registers cleared. A half-assembled pair is discarded. The word presented in the same cycle is dropped.
- issued_count increments by 1 on each cycle where out_valid is registered 1. Wraps 0xFFFF->0x0000. Not cleared by flush.
- Reset asserted mid-pair: pair discarded, all outputs return to reset values immediately (async).

Decomposition:
- Shared package: WORD_W, PC_W, NOP_WORD=16'h0000, IMM_GROUP=3'b110, opcode field slice [15:13], state encoding ST_FIRST=1'b0 / ST_IMM=1'b1.
- One sub-module, imm_classifier: combinational is_imm(word) used here and later by Decode.
- Remainder: FSM, hold registers, output registers, counter.

Test Plan:
- Reset then words 16'h1234@pc0, 16'h2001@pc4, no stall -> out_valid 1 on cycles 1,2 with instructions 1234/2001, immediate 0, pc 0/4; issued_count=2.
- Word 16'hC005@pc8 then 16'h00FF@pc12 -> cycle 1 out_valid=0. Cycle 2 out_instruction=C005, out_immediate=00FF, out_has_imm=1, out_pc=8.
- Stall for 3 cycles between C005 and its immediate -> in_ready=0 and outputs frozen during stall. Pair completes the cycle after stall drops, with out_pc=8.
- Flush while in ST_IMM (after C005), then 16'h1111@pc20 -> C005 discarded. Next valid output is 1111/pc20 with has_imm=0.
- flush and stall asserted together with in_valid=1 -> word dropped, out_valid=0, state ST_FIRST.
- 65537 back-to-back non-imm words -> issued_count wraps to 1. Async reset pulse mid-pair -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared IF/ID definitions: word widths, the immediate opcode group and FSM encoding.
package fetch_decode_buffer_pkg;

   localparam int          WORD_W    = 16;
   localparam int          PC_W      = 32;
   localparam logic [15:0] NOP_WORD  = 16'h0000;
   localparam int          OPC_HI    = 15;
   localparam int          OPC_LO    = 13;
   localparam logic [2:0]  IMM_GROUP = 3'b110;

   localparam logic [0:0]  ST_FIRST  = 1'b0;
   localparam logic [0:0]  ST_IMM    = 1'b1;

endpackage

// File: rtl/fetch_decode_buffer_imm_classifier.sv
// Flags words whose opcode group means the next fetched word is their immediate.
module imm_classifier
   import fetch_decode_buffer_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   output logic              is_imm
);

   assign is_imm = (word[OPC_HI:OPC_LO] == IMM_GROUP);

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID buffer: pairs immediate-bearing instructions with their trailing word and
// presents whole instructions to Decode, honouring stall and flush.
module fetch_decode_buffer
   import fetch_decode_buffer_pkg::*;
#(
   parameter int PC_W   = fetch_decode_buffer_pkg::PC_W,
   parameter int WORD_W = fetch_decode_buffer_pkg::WORD_W,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_word,
   input  logic [PC_W-1:0]   in_pc,
   output logic              in_ready,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_instruction,
   output logic [WORD_W-1:0] out_immediate,
   output logic              out_has_imm,
   output logic [PC_W-1:0]   out_pc,
   output logic [CNT_W-1:0]  issued_count
);

   logic              accept;
   logic              word_is_imm;

   logic [0:0]        state_p0;
   logic [WORD_W-1:0] hold_instr_p0;
   logic [PC_W-1:0]   hold_pc_p0;

   logic              vld_p1;
   logic [WORD_W-1:0] instr_p1;
   logic [WORD_W-1:0] imm_p1;
   logic              has_imm_p1;
   logic [PC_W-1:0]   pc_p1;
   logic [CNT_W-1:0]  cnt_p1;

   assign in_ready = !stall && !flush;
   assign accept   = in_valid && in_ready;

   imm_classifier u_imm_classifier (
      .word   (in_word),
      .is_imm (word_is_imm)
   );

   // p0 -> p1: pair assembly and Decode-facing output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_p0      <= ST_FIRST;
         hold_instr_p0 <= NOP_WORD;
         hold_pc_p0    <= '0;
         vld_p1        <= 1'b0;
         instr_p1      <= NOP_WORD;
         imm_p1        <= '0;
         has_imm_p1    <= 1'b0;
         pc_p1         <= '0;
         cnt_p1        <= '0;
      end else if (flush) begin
         state_p0      <= ST_FIRST;
         hold_instr_p0 <= NOP_WORD;
         hold_pc_p0    <= '0;
         vld_p1        <= 1'b0;
         instr_p1      <= NOP_WORD;
         imm_p1        <= '0;
         has_imm_p1    <= 1'b0;
         pc_p1         <= '0;
      end else if (!stall) begin
         // Default is a bubble; only a completed instruction overrides it.
         vld_p1     <= 1'b0;
         instr_p1   <= NOP_WORD;
         imm_p1     <= '0;
         has_imm_p1 <= 1'b0;
         pc_p1      <= '0;
         if (accept) begin
            if (state_p0 == ST_IMM) begin
               vld_p1     <= 1'b1;
               instr_p1   <= hold_instr_p0;
               imm_p1     <= in_word;
               has_imm_p1 <= 1'b1;
               pc_p1      <= hold_pc_p0;
               cnt_p1     <= cnt_p1 + 1'b1;
               state_p0   <= ST_FIRST;
            end else if (word_is_imm) begin
               hold_instr_p0 <= in_word;
               hold_pc_p0    <= in_pc;
               state_p0      <= ST_IMM;
            end else begin
               vld_p1   <= 1'b1;
               instr_p1 <= in_word;
               pc_p1    <= in_pc;
               cnt_p1   <= cnt_p1 + 1'b1;
            end
         end
      end
   end

   assign out_valid       = vld_p1;
   assign out_instruction = instr_p1;
   assign out_immediate   = imm_p1;
   assign out_has_imm     = has_imm_p1;
   assign out_pc          = pc_p1;
   assign issued_count    = cnt_p1;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer with hand-computed expectations.
module tb_fetch_decode_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_word;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic        out_valid;
   logic [15:0] out_instruction;
   logic [15:0] out_immediate;
   logic        out_has_imm;
   logic [31:0] out_pc;
   logic [15:0] issued_count;

   int n_chk;
   int n_fail;

   fetch_decode_buffer dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_word         (in_word),
      .in_pc           (in_pc),
      .in_ready        (in_ready),
      .stall           (stall),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_immediate   (out_immediate),
      .out_has_imm     (out_has_imm),
      .out_pc          (out_pc),
      .issued_count    (issued_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic vld, input logic [15:0] ins,
                            input logic [15:0] imm, input logic has, input logic [31:0] pc,
                            input logic [15:0] cnt);
      check({tag, ".valid"}, 64'(out_valid), 64'(vld));
      check({tag, ".instr"}, 64'(out_instruction), 64'(ins));
      check({tag, ".imm"},   64'(out_immediate), 64'(imm));
      check({tag, ".has"},   64'(out_has_imm), 64'(has));
      check({tag, ".pc"},    64'(out_pc), 64'(pc));
      check({tag, ".cnt"},   64'(issued_count), 64'(cnt));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc);
      in_valid = v;
      in_word  = w;
      in_pc    = pc;
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_word  = '0;
      in_pc    = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_out("reset", 1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 16'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Back-to-back plain instructions
      drive(1'b1, 16'h1234, 32'd0);
      #1 check("in_ready_idle", 64'(in_ready), 64'd1);
      cyc();
      check_out("plain0", 1'b1, 16'h1234, 16'h0, 1'b0, 32'd0, 16'd1);
      drive(1'b1, 16'h2001, 32'd4);
      cyc();
      check_out("plain1", 1'b1, 16'h2001, 16'h0, 1'b0, 32'd4, 16'd2);

      // Immediate pair
      drive(1'b1, 16'hC005, 32'd8);
      cyc();
      check_out("pair_bubble", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd2);
      drive(1'b1, 16'h00FF, 32'd12);
      cyc();
      check_out("pair_done", 1'b1, 16'hC005, 16'h00FF, 1'b1, 32'd8, 16'd3);

      // Stall between an immediate instruction and its immediate
      drive(1'b1, 16'hC005, 32'd8);
      cyc();
      drive(1'b1, 16'h00FF, 32'd12);
      stall = 1'b1;
      #1 check("in_ready_stall", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_out("stall_pair", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd3);
      end
      stall = 1'b0;
      cyc();
      check_out("stall_pair_done", 1'b1, 16'hC005, 16'h00FF, 1'b1, 32'd8, 16'd4);

      // Stall while a valid instruction is on the outputs: it must be held
      drive(1'b1, 16'h1234, 32'h30);
      cyc();
      check_out("pre_hold", 1'b1, 16'h1234, 16'h0, 1'b0, 32'h30, 16'd5);
      drive(1'b1, 16'h4444, 32'h34);
      stall = 1'b1;
      repeat (2) begin
         cyc();
         check_out("stall_hold", 1'b1, 16'h1234, 16'h0, 1'b0, 32'h30, 16'd5);
      end
      stall = 1'b0;

      // Flush in ST_IMM discards the half pair
      drive(1'b1, 16'hC005, 32'd16);
      cyc();
      check_out("hold_4444", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd5);
      drive(1'b1, 16'h00FF, 32'd18);
      flush = 1'b1;
      #1 check("in_ready_flush", 64'(in_ready), 64'd0);
      cyc();
      check_out("flush", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd5);
      flush = 1'b0;
      drive(1'b1, 16'h1111, 32'd20);
      cyc();
      check_out("after_flush", 1'b1, 16'h1111, 16'h0, 1'b0, 32'd20, 16'd6);

      // Flush and stall together, word dropped
      drive(1'b1, 16'hC005, 32'd24);
      cyc();
      drive(1'b1, 16'h2222, 32'd28);
      flush = 1'b1;
      stall = 1'b1;
      cyc();
      check_out("flush_stall", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd6);
      flush = 1'b0;
      stall = 1'b0;
      drive(1'b1, 16'h3333, 32'd32);
      cyc();
      check_out("after_fs", 1'b1, 16'h3333, 16'h0, 1'b0, 32'd32, 16'd7);
      drive(1'b0, 16'h5555, 32'd36);
      cyc();
      check_out("idle", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd7);

      // Idle gaps inside a pair; immediate word looks like an imm opcode
      drive(1'b1, 16'hC005, 32'd40);
      cyc();
      drive(1'b0, 16'h0, 32'd0);
      repeat (2) begin
         cyc();
         check_out("imm_wait", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd7);
      end
      drive(1'b1, 16'hCAFE, 32'd44);
      cyc();
      check_out("imm_gap_done", 1'b1, 16'hC005, 16'hCAFE, 1'b1, 32'd40, 16'd8);

      // Asynchronous reset mid-pair
      drive(1'b1, 16'h1234, 32'd48);
      cyc();
      check_out("pre_reset", 1'b1, 16'h1234, 16'h0, 1'b0, 32'd48, 16'd9);
      drive(1'b1, 16'hC005, 32'd52);
      cyc();
      #1 reset = 1'b1;
      #1;
      check_out("async_reset", 1'b0, 16'h0, 16'h0, 1'b0, 32'd0, 16'd0);
      @(negedge clk) reset = 1'b0;
      drive(1'b1, 16'h00FF, 32'd56);
      cyc();
      check_out("post_reset", 1'b1, 16'h00FF, 16'h0, 1'b0, 32'd56, 16'd1);

      // Counter wrap: 65536 more plain words after the one above
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 16'h0100, 32'(i) << 1);
         @(posedge clk);
      end
      #1;
      check_out("wrap", 1'b1, 16'h0100, 16'h0, 1'b0, 32'h1FFFE, 16'd1);
      drive(1'b0, 16'h0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
